// File: rtl/mult_pkg.sv
// Shared definitions for the two-requester multiplier arbiter.
//   N_DEF       : default operand width (result is 2*N_DEF bits)
//   TIMEOUT_DEF : default number of WAIT cycles before a transaction errors out
//   state_t     : arbiter FSM state encoding
package mult_pkg;

    localparam int N_DEF       = 4;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADB = 3'd1,
        ST_LOADQ = 3'd2,
        ST_GO    = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Bundle between two requesters plus an external sequential multiplier
// (master side) and the arbiter (slave side).
//   REQ[i], OPA*/OPB*         : request levels and operands of requester i
//   ACK[i]                    : one-cycle pulse, operands of requester i captured
//   DONE[i], ERR, RESULT      : one-cycle completion pulse with status and product
//   MULT_LOADB/LOADQ/G/IN     : control and operand bus towards the multiplier
//   MULT_OUT, MULT_FINISH     : product and completion level from the multiplier
//
// Handshake: a requester raises REQ[i] with its operands stable and keeps both
// unchanged until it sees ACK[i] high for one cycle; REQ[i] still high in the
// cycle after ACK[i] counts as a fresh request. DONE[i] is a single-cycle
// pulse with no back-pressure, and ERR/RESULT are meaningful only while DONE
// is high.
interface mult_arbiter_if
    import mult_pkg::*;
#(
    parameter int N = N_DEF
);
    logic [1:0]     REQ;
    logic [N-1:0]   OPA0;
    logic [N-1:0]   OPA1;
    logic [N-1:0]   OPB0;
    logic [N-1:0]   OPB1;
    logic [1:0]     ACK;
    logic [1:0]     DONE;
    logic           ERR;
    logic [2*N-1:0] RESULT;
    logic           MULT_LOADB;
    logic           MULT_LOADQ;
    logic           MULT_G;
    logic [N-1:0]   MULT_IN;
    logic [2*N-1:0] MULT_OUT;
    logic           MULT_FINISH;

    modport master (
        output REQ, OPA0, OPA1, OPB0, OPB1, MULT_OUT, MULT_FINISH,
        input  ACK, DONE, ERR, RESULT, MULT_LOADB, MULT_LOADQ, MULT_G, MULT_IN
    );

    modport slave (
        input  REQ, OPA0, OPA1, OPB0, OPB1, MULT_OUT, MULT_FINISH,
        output ACK, DONE, ERR, RESULT, MULT_LOADB, MULT_LOADQ, MULT_G, MULT_IN
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, purely combinational.
//   req       : request bits, bit i = requester i
//   last      : index of the requester granted most recently
//   gnt_valid : at least one request present
//   gnt_idx   : index of the winner (the one not granted last on a tie)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates two requesters onto one external sequential multiplier.
// A granted transaction walks IDLE -> LOADB -> LOADQ -> GO -> WAIT -> RESP.
//   CLK, RESET_N : clock and synchronous active-low reset
//   bus          : requester and multiplier signals (slave view)
//   dbg_state    : current FSM state, for observation only
module mult_arbiter
    import mult_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          CLK,
    input  logic          RESET_N,
    mult_arbiter_if.slave bus,
    output state_t        dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           idx_q, idx_d;
    logic [N-1:0]   opa_q, opa_d;
    logic [N-1:0]   opb_q, opb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           fin_prev_q, fin_prev_d;
    logic [1:0]     ack_q, ack_d;
    logic [1:0]     done_q, done_d;
    logic           err_q, err_d;
    logic [2*N-1:0] result_q, result_d;
    logic           loadb_q, loadb_d;
    logic           loadq_q, loadq_d;
    logic           g_q, g_d;
    logic [N-1:0]   mult_in_q, mult_in_d;

    logic           gnt_valid;
    logic           gnt_idx;

    rr_arb2 u_rr (
        .req       (bus.REQ),
        .last      (last_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        idx_d      = idx_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        cnt_d      = cnt_q;
        fin_prev_d = bus.MULT_FINISH;
        ack_d      = 2'b00;
        done_d     = 2'b00;
        err_d      = 1'b0;
        result_d   = '0;

        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    idx_d   = gnt_idx;
                    last_d  = gnt_idx;
                    opa_d   = gnt_idx ? bus.OPA1 : bus.OPA0;
                    opb_d   = gnt_idx ? bus.OPB1 : bus.OPB0;
                    ack_d   = gnt_idx ? 2'b10 : 2'b01;
                    state_d = ST_LOADB;
                end
            end
            ST_LOADB: state_d = ST_LOADQ;
            ST_LOADQ: state_d = ST_GO;
            ST_GO: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only a fresh rising edge counts; a level left high by an
                // earlier operation must not end this one.
                if (bus.MULT_FINISH && !fin_prev_q) begin
                    result_d = bus.MULT_OUT;
                    done_d   = idx_q ? 2'b10 : 2'b01;
                    state_d  = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    done_d  = idx_q ? 2'b10 : 2'b01;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Multiplier controls are decoded from the next state so they are
        // registered together with it and line up with the state cycle.
        loadb_d   = (state_d == ST_LOADB);
        loadq_d   = (state_d == ST_LOADQ);
        g_d       = (state_d == ST_GO);
        mult_in_d = loadb_d ? opa_d : (loadq_d ? opb_d : '0);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b1;
            idx_q      <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            cnt_q      <= '0;
            fin_prev_q <= 1'b0;
            ack_q      <= 2'b00;
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            result_q   <= '0;
            loadb_q    <= 1'b0;
            loadq_q    <= 1'b0;
            g_q        <= 1'b0;
            mult_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            cnt_q      <= cnt_d;
            fin_prev_q <= fin_prev_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            err_q      <= err_d;
            result_q   <= result_d;
            loadb_q    <= loadb_d;
            loadq_q    <= loadq_d;
            g_q        <= g_d;
            mult_in_q  <= mult_in_d;
        end
    end

    assign bus.ACK        = ack_q;
    assign bus.DONE       = done_q;
    assign bus.ERR        = err_q;
    assign bus.RESULT     = result_q;
    assign bus.MULT_LOADB = loadb_q;
    assign bus.MULT_LOADQ = loadq_q;
    assign bus.MULT_G     = g_q;
    assign bus.MULT_IN    = mult_in_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: a behavioural multiplier stub, a transaction-level
// expectation timeline, one per-cycle compare process and directed literals.
module tb_mult_arbiter;
    import mult_pkg::*;

    localparam int N    = N_DEF;
    localparam int W    = 2 * N;
    localparam int TO   = TIMEOUT_DEF;
    localparam int MAXC = 4096;

    typedef struct packed {
        logic [1:0]   ack;
        logic [1:0]   done;
        logic         err;
        logic [W-1:0] res;
        logic         lb;
        logic         lq;
        logic         g;
        logic [N-1:0] mbus;
    } exp_t;

    logic   CLK = 1'b0;
    logic   RESET_N;
    state_t dbg_state;

    mult_arbiter_if #(.N(N)) bus_if ();

    mult_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .bus       (bus_if),
        .dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- expectation timeline (model) ----------------
    exp_t         exp_tab [MAXC];
    int           free_at;
    int           ws;
    bit           resolved;
    bit           last_g;
    bit           cur_idx;
    logic [W-1:0] cur_prod;
    logic         fin_prev_m;

    // ---------------- observation log ----------------
    int           ack_cnt = 0;
    int           done_cnt = 0;
    int           last_ack_cyc, last_done_cyc;
    int           last_done_idx, last_done_err;
    logic [W-1:0] last_done_res;
    int           ack_order_q[$];
    logic [W-1:0] done_res_q[$];

    task automatic put_done(input int c, input bit idx, input bit err, input logic [W-1:0] res);
        if (c < MAXC) begin
            exp_tab[c].done = idx ? 2'b10 : 2'b01;
            exp_tab[c].err  = err;
            exp_tab[c].res  = res;
        end
    endtask

    always @(negedge CLK) begin
        exp_t         e;
        bit           win;
        logic [N-1:0] a, b;
        if (cyc >= 1 && cyc < MAXC) begin
            e = exp_tab[cyc];
            chk("handshake", {28'd0, bus_if.ACK, bus_if.DONE}, {28'd0, e.ack, e.done});
            chk("result", {23'd0, bus_if.ERR, bus_if.RESULT}, {23'd0, e.err, e.res});
            chk("mult_bus", {25'd0, bus_if.MULT_LOADB, bus_if.MULT_LOADQ, bus_if.MULT_G, bus_if.MULT_IN},
                {25'd0, e.lb, e.lq, e.g, e.mbus});
        end
        if (bus_if.ACK != 2'b00) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            ack_order_q.push_back(int'(bus_if.ACK[1]));
        end
        if (bus_if.DONE != 2'b00) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_done_idx = int'(bus_if.DONE[1]);
            last_done_err = int'(bus_if.ERR);
            last_done_res = bus_if.RESULT;
            done_res_q.push_back(bus_if.RESULT);
        end

        // Advance the model with what the DUT samples at the coming edge.
        if (!RESET_N) begin
            for (int k = cyc + 1; k < MAXC; k++) exp_tab[k] = '0;
            free_at  = cyc + 1;
            resolved = 1'b1;
            last_g   = 1'b1;
        end else begin
            if (!resolved && cyc >= ws) begin
                if (bus_if.MULT_FINISH && !fin_prev_m) begin
                    put_done(cyc + 1, cur_idx, 1'b0, cur_prod);
                    resolved = 1'b1;
                    free_at  = cyc + 2;
                end else if (cyc - ws == TO - 1) begin
                    put_done(cyc + 1, cur_idx, 1'b1, '0);
                    resolved = 1'b1;
                    free_at  = cyc + 2;
                end
            end
            if (cyc >= free_at && bus_if.REQ != 2'b00 && cyc + 4 < MAXC) begin
                win    = (bus_if.REQ == 2'b11) ? !last_g : bus_if.REQ[1];
                last_g = win;
                a      = win ? bus_if.OPA1 : bus_if.OPA0;
                b      = win ? bus_if.OPB1 : bus_if.OPB0;
                exp_tab[cyc + 1].ack  = win ? 2'b10 : 2'b01;
                exp_tab[cyc + 1].lb   = 1'b1;
                exp_tab[cyc + 1].mbus = a;
                exp_tab[cyc + 2].lq   = 1'b1;
                exp_tab[cyc + 2].mbus = b;
                exp_tab[cyc + 3].g    = 1'b1;
                ws       = cyc + 4;
                resolved = 1'b0;
                free_at  = MAXC + 1000;
                cur_idx  = win;
                cur_prod = W'(a) * W'(b);
            end
        end
        fin_prev_m = bus_if.MULT_FINISH;
    end

    // ---------------- external multiplier stub ----------------
    // mode 0: FINISH rises d cycles into WAIT; mode 1: never finishes;
    // mode 2: FINISH held high into WAIT, low for two cycles from index d, then high.
    int           force_mode = -1;
    int           force_d    = 0;
    int           mode       = 1;
    int           sdel       = 0;
    bit           armed      = 1'b0;
    int           g_cyc      = 0;
    logic [N-1:0] sb, sq;
    logic [W-1:0] prod = '0;

    always @(negedge CLK) begin
        int r;
        if (bus_if.MULT_LOADB) begin
            sb    = bus_if.MULT_IN;
            armed = 1'b0;
            if (force_mode >= 0) begin
                mode = force_mode;
                sdel = force_d;
            end else begin
                r = $urandom_range(0, 19);
                if (r < 16) begin
                    mode = 0;
                    sdel = $urandom_range(0, 5);
                end else if (r < 19) begin
                    mode = 2;
                    sdel = $urandom_range(0, 3);
                end else begin
                    mode = 1;
                end
            end
        end
        if (bus_if.MULT_LOADQ) sq = bus_if.MULT_IN;
        if (bus_if.MULT_G) begin
            armed = 1'b1;
            g_cyc = cyc;
            prod  = W'(sb) * W'(sq);
        end
    end

    always @(posedge CLK) begin
        int   w;
        logic fin;
        #1;
        w = cyc - (g_cyc + 1);
        case (mode)
            0:       fin = armed && (w >= sdel);
            1:       fin = 1'b0;
            default: fin = !armed || (w < sdel) || (w >= sdel + 2);
        endcase
        bus_if.MULT_FINISH = fin;
        bus_if.MULT_OUT    = fin ? prod : W'($urandom);
    end

    // ---------------- driver ----------------
    logic [1:0] hold = 2'b00;

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++)
            if (bus_if.ACK[i] && !hold[i]) bus_if.REQ[i] = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int start = done_cnt;
        int k = 0;
        while (done_cnt == start && k < max_cycles) begin
            tick();
            k++;
        end
        chk("done_arrives", {31'd0, done_cnt != start}, 32'd1);
    endtask

    task automatic run_one(input bit idx, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int m, input int d);
        force_mode = m;
        force_d    = d;
        if (idx) begin
            bus_if.OPA1 = a;
            bus_if.OPB1 = b;
        end else begin
            bus_if.OPA0 = a;
            bus_if.OPB0 = b;
        end
        bus_if.REQ[idx] = 1'b1;
        wait_done(200);
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
    endtask

    initial begin
        int start, k;
        for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
        free_at    = 0;
        ws         = 0;
        resolved   = 1'b1;
        last_g     = 1'b1;
        cur_idx    = 1'b0;
        cur_prod   = '0;
        fin_prev_m = 1'b0;
        RESET_N    = 1'b0;
        bus_if.REQ  = 2'b00;
        bus_if.OPA0 = '0;
        bus_if.OPA1 = '0;
        bus_if.OPB0 = '0;
        bus_if.OPB1 = '0;
        bus_if.MULT_FINISH = 1'b0;
        bus_if.MULT_OUT    = '0;

        repeat (3) tick();
        chk("state_after_reset", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        RESET_N = 1'b1;
        tick();

        // 3 x 2 from requester 0, finish two cycles into WAIT
        run_one(1'b0, 4'd3, 4'd2, 0, 2);
        chk("r0_result", last_done_res, 6);
        chk("r0_idx", last_done_idx, 0);
        chk("r0_err", last_done_err, 0);
        chk("r0_latency", last_done_cyc - last_ack_cyc, 6);

        run_one(1'b1, 4'd7, 4'd5, 0, 0);
        chk("r1_result", last_done_res, 35);
        chk("r1_idx", last_done_idx, 1);
        run_one(1'b0, 4'd15, 4'd15, 0, 3);
        chk("max_result", last_done_res, 225);

        // Both held high after reset: strict alternation starting at 0
        pulse_reset();
        ack_order_q.delete();
        done_res_q.delete();
        force_mode  = 0;
        force_d     = 1;
        hold        = 2'b11;
        bus_if.OPA0 = 4'd2;
        bus_if.OPB0 = 4'd3;
        bus_if.OPA1 = 4'd5;
        bus_if.OPB1 = 4'd4;
        bus_if.REQ  = 2'b11;
        repeat (4) wait_done(200);
        hold = 2'b00;
        k = 0;
        while (bus_if.REQ != 2'b00 && k < 200) begin
            tick();
            k++;
        end
        repeat (20) tick();
        chk("rr_count", ack_order_q.size() >= 4, 1);
        if (ack_order_q.size() >= 4) begin
            chk("rr_grant0", ack_order_q[0], 0);
            chk("rr_grant1", ack_order_q[1], 1);
            chk("rr_grant2", ack_order_q[2], 0);
            chk("rr_grant3", ack_order_q[3], 1);
            chk("rr_res0", done_res_q[0], 6);
            chk("rr_res1", done_res_q[1], 20);
            chk("rr_res2", done_res_q[2], 6);
            chk("rr_res3", done_res_q[3], 20);
        end

        // Multiplier never finishes: error after the full WAIT budget
        run_one(1'b0, 4'd9, 4'd9, 1, 0);
        chk("to_err", last_done_err, 1);
        chk("to_result", last_done_res, 0);
        chk("to_latency", last_done_cyc - last_ack_cyc, TO + 3);

        // FINISH stuck high on WAIT entry, falls at index 1, rises at index 3
        run_one(1'b1, 4'd6, 4'd7, 2, 1);
        chk("stuck_result", last_done_res, 42);
        chk("stuck_err", last_done_err, 0);
        chk("stuck_latency", last_done_cyc - last_ack_cyc, 7);

        // Reset in the middle of WAIT abandons the transaction
        force_mode  = 1;
        bus_if.OPA0 = 4'd4;
        bus_if.OPB0 = 4'd4;
        bus_if.REQ[0] = 1'b1;
        start = ack_cnt;
        k = 0;
        while (ack_cnt == start && k < 50) begin
            tick();
            k++;
        end
        chk("reset_case_ack", {31'd0, ack_cnt != start}, 32'd1);
        repeat (10) tick();
        start = done_cnt;
        pulse_reset();
        repeat (80) tick();
        chk("no_done_after_reset", done_cnt, start);
        run_one(1'b0, 4'd4, 4'd5, 0, 1);
        chk("post_reset_result", last_done_res, 20);

        // Random traffic against the model
        force_mode = -1;
        for (int t = 0; t < 1500; t++) begin
            tick();
            if (bus_if.REQ[0] == 1'b0 && $urandom_range(0, 3) == 0) begin
                bus_if.OPA0   = N'($urandom);
                bus_if.OPB0   = N'($urandom);
                bus_if.REQ[0] = 1'b1;
            end
            if (bus_if.REQ[1] == 1'b0 && $urandom_range(0, 3) == 0) begin
                bus_if.OPA1   = N'($urandom);
                bus_if.OPB1   = N'($urandom);
                bus_if.REQ[1] = 1'b1;
            end
        end
        k = 0;
        while (bus_if.REQ != 2'b00 && k < 1000) begin
            tick();
            k++;
        end
        chk("drain", {30'd0, bus_if.REQ}, 32'd0);
        repeat (150) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
